// File: rtl/ibex_obi_mem_responder.sv
// OBI-style memory responder: byte-enable SRAM behind an in-order response FIFO.
// Optional access counters are enabled with `define IBEX_OBI_MEM_STATS_EN.
module ibex_obi_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
`ifdef IBEX_OBI_MEM_STATS_EN
    output logic [31:0] stat_reads_o,
    output logic [31:0] stat_writes_o,
    output logic [31:0] stat_errs_o,
`endif
    input  logic        stall_i
);

    localparam int unsigned AddrW    = $clog2(MemWords);
    localparam int unsigned PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam logic [31:0] MemBytes = 32'(MemWords) << 2;

    logic [31:0]      offset;
    logic             in_range;
    logic [AddrW-1:0] word_idx;
    logic             accept;
    logic             pop;
    logic [31:0]      rd_word;

    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] fifo_rdata_q [MaxOutstanding];
    logic        fifo_err_q   [MaxOutstanding];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Unsigned subtraction folds the below-base case into the same compare.
    assign offset   = addr_i - BaseAddr;
    assign in_range = offset < MemBytes;
    assign word_idx = offset[AddrW+1:2];

    assign gnt_o    = rst_ni & ~stall_i & (count_q < CntW'(MaxOutstanding));
    assign rvalid_o = rst_ni & ~stall_i & (count_q != '0);
    assign accept   = req_i & gnt_o;
    assign pop      = rvalid_o;

    assign rdata_o  = rvalid_o ? fifo_rdata_q[rd_ptr_q] : 32'h0;
    assign err_o    = rvalid_o ? fifo_err_q[rd_ptr_q] : 1'b0;

    // One byte-wide array per lane so each lane write-enable maps to its own RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [MemWords];

        always_ff @(posedge clk_i) begin
            if (accept && we_i && in_range && be_i[gi]) begin
                lane_mem[word_idx] <= wdata_i[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end

    // Read data is captured into the FIFO slot at the accept edge (read-before-write).
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_rdata_q[wr_ptr_q] <= (in_range && !we_i) ? rd_word : 32'h0;
            fifo_err_q[wr_ptr_q]   <= ~in_range;
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef IBEX_OBI_MEM_STATS_EN
    logic [31:0] reads_q, reads_d;
    logic [31:0] writes_q, writes_d;
    logic [31:0] errs_q, errs_d;

    always_comb begin
        reads_d  = reads_q  + 32'(accept && in_range && !we_i);
        writes_d = writes_q + 32'(accept && in_range && we_i);
        errs_d   = errs_q   + 32'(accept && !in_range);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            reads_q  <= '0;
            writes_q <= '0;
            errs_q   <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            errs_q   <= errs_d;
        end
    end

    assign stat_reads_o  = reads_q;
    assign stat_writes_o = writes_q;
    assign stat_errs_o   = errs_q;
`endif

endmodule

// File: doc/ibex_obi_mem_responder.md
Name: ibex_obi_mem_responder

Overview:
- Memory-side responder for the core's instruction or data request/grant/rvalid bus; it sits opposite ibex_core's instr_* or data_* initiator ports in simulation and verification tops.
- Backed by a word-addressed SRAM array with byte-enable writes.
- Accepts requests in order, queues responses in an outstanding-response FIFO and returns them in order.
- Returns an error response for out-of-range addresses; a stall input throttles it for stress testing.

Parameters:
- MemWords, 1024: number of 32-bit words in the array (power of two, >= 4).
- BaseAddr, 32'h00000000: byte address of word 0; must be aligned to 4*MemWords.
- MaxOutstanding, 2: response FIFO depth, i.e. maximum accepted-but-unanswered requests (1..8).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  request valid from initiator
- gnt_o  out  1  request accepted this cycle when req_i & gnt_o
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- addr_i  in  32  byte address; bits [1:0] ignored
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one cycle per accepted request
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  error response, qualified by rvalid_o
- stall_i  in  1  verification throttle; blocks grant and response

Behaviour:
- Reset: one clock, synchronous, active-low. rst_ni low at a rising edge flushes the FIFO (count=0) and clears the read/write pointers.
  - During and after reset: rvalid_o=0, rdata_o=0, err_o=0.
  - gnt_o=0 while rst_ni low.
  - Array contents are not reset and survive reset, including writes accepted before reset.
  - A reset mid-operation discards all pending responses; no rvalid is issued for them.
- Grant: gnt_o = rst_ni & ~stall_i & (count < MaxOutstanding). It is combinational from registered count only; no path from req_i. It does not consider a same-cycle pop.
- Accept, when req_i & gnt_o:
  - In-range test: (addr_i - BaseAddr) < 4*MemWords, unsigned 32-bit. Index = (addr_i - BaseAddr)[log2(MemWords)+1:2].
  - In-range read: the array word at the index is pushed as {err=0, rdata=word}. The value is sampled in the acceptance cycle, before any write at the same edge.
  - In-range write: bytes with be_i[k]=1 are updated from wdata_i[8k+7:8k] at the edge. Push {err=0, rdata=0}. be_i=4'b0000 leaves memory unchanged and still gives a normal response.
  - Out-of-range (read or write): no array access. Push {err=1, rdata=0}.
- Response:
  - rvalid_o = (count != 0) & ~stall_i. rdata_o and err_o are the FIFO head when rvalid_o=1, and 0 otherwise.
  - The head is popped on every cycle with rvalid_o=1.
  - Minimum latency is 1 cycle: accept in cycle N gives rvalid in cycle N+1.
  - Responses are strictly in acceptance order; at most one per cycle. There is no rvalid back-pressure.
- Simultaneous push and pop: count unchanged; pointers both advance modulo MaxOutstanding.
- Full (count = MaxOutstanding): gnt_o=0; the held req_i is granted the cycle after a pop makes room.
- Empty: rvalid_o=0.
- stall_i=1: gnt_o=0 and rvalid_o=0 in that cycle; FIFO and array state are held.
- Read after write: a read accepted at least one cycle after a write to the same word returns the new data.

Optional Feature:
- Macro: IBEX_OBI_MEM_STATS_EN.
- Defined: three extra outputs, each a 32-bit counter:
  - stat_reads_o: accepted in-range reads.
  - stat_writes_o: accepted in-range writes.
  - stat_errs_o: accepted out-of-range requests.
  - Counters clear on reset, increment in the acceptance cycle, and wrap from 32'hFFFFFFFF to 0.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then write 0xDEADBEEF (be=4'hF) to BaseAddr+0x10, then read it → write response err=0 rdata=0 at N+1; read returns 0xDEADBEEF one cycle after its grant.
- Write 0x11223344 with be=4'b0101 over 0xFFFFFFFF → a later read returns 0xFF22FF44.
- Read address BaseAddr+4*MemWords and write BaseAddr-4 → both give rvalid with err_o=1, rdata_o=0; the array is unchanged.
- stall_i=1 for 5 cycles while req_i=1, then release with back-to-back reads (MaxOutstanding=2):
  - gnt_o=0 throughout the stall.
  - Afterwards gnt_o=1 every cycle and one rvalid per cycle, in order.
- Accept 2 reads, hold stall_i=1 so count=2, keep req_i=1 → gnt_o stays 0; it regrants the cycle after the first pop.
- With 2 responses pending, drive rst_ni=0 for one cycle → no rvalid for the flushed requests; a previously written word still reads back intact.
